// File: rtl/wb_grf.sv
// Writeback stage and general register file for the 5-stage MIPS pipeline.
// Selects/extends the W-stage result, commits it, serves D-stage reads with bypass.
module wb_grf #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          reg_write_w,
  input  logic [1:0]    wb_sel_w,
  input  logic [2:0]    load_type_w,
  input  logic [DW-1:0] read_data_w,
  input  logic [DW-1:0] alu_out_w,
  input  logic [4:0]    write_reg_w,
  input  logic [DW-1:0] pc_w,
  input  logic [DW-1:0] pc_plus_8_w,
  input  logic [DW-1:0] reg_data_w,
  input  logic [4:0]    rs_addr_d,
  input  logic [4:0]    rt_addr_d,
  output logic [DW-1:0] rs_data_d,
  output logic [DW-1:0] rt_data_d,
  output logic [DW-1:0] wb_data_w,
  output logic          trace_en,
  output logic [DW-1:0] trace_pc,
  output logic [4:0]    trace_addr,
  output logic [DW-1:0] trace_data
);

  localparam logic [2:0] LT_LBU = 3'd1;
  localparam logic [2:0] LT_LB  = 3'd2;
  localparam logic [2:0] LT_LHU = 3'd3;
  localparam logic [2:0] LT_LH  = 3'd4;

  logic [DW-1:0] regs [NREG];
  logic [1:0]    off;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [DW-1:0] load_ext;
  logic          we;

  assign off = alu_out_w[1:0];

  always_comb begin
    byte_sel = read_data_w[7:0];
    case (off)
      2'd1:    byte_sel = read_data_w[15:8];
      2'd2:    byte_sel = read_data_w[23:16];
      2'd3:    byte_sel = read_data_w[31:24];
      default: byte_sel = read_data_w[7:0];
    endcase
    // Halfword lane picked by off[1] only; misalignment is not trapped here.
    half_sel = off[1] ? read_data_w[31:16] : read_data_w[15:0];
  end

  always_comb begin
    load_ext = read_data_w;
    case (load_type_w)
      LT_LBU:  load_ext = {{(DW-8){1'b0}}, byte_sel};
      LT_LB:   load_ext = {{(DW-8){byte_sel[7]}}, byte_sel};
      LT_LHU:  load_ext = {{(DW-16){1'b0}}, half_sel};
      LT_LH:   load_ext = {{(DW-16){half_sel[15]}}, half_sel};
      default: load_ext = read_data_w;
    endcase
  end

  always_comb begin
    wb_data_w = alu_out_w;
    case (wb_sel_w)
      2'd1:    wb_data_w = load_ext;
      2'd2:    wb_data_w = pc_plus_8_w;
      2'd3:    wb_data_w = reg_data_w;
      default: wb_data_w = alu_out_w;
    endcase
  end

  assign we = reg_write_w & ~reset & (write_reg_w != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[write_reg_w] <= wb_data_w;
    end
  end

  // Same-cycle bypass lets a D-stage read see the W-stage result without a stall.
  always_comb begin
    if (rs_addr_d == 5'd0)
      rs_data_d = '0;
    else if (we && (rs_addr_d == write_reg_w))
      rs_data_d = wb_data_w;
    else
      rs_data_d = regs[rs_addr_d];

    if (rt_addr_d == 5'd0)
      rt_data_d = '0;
    else if (we && (rt_addr_d == write_reg_w))
      rt_data_d = wb_data_w;
    else
      rt_data_d = regs[rt_addr_d];
  end

  assign trace_en   = we;
  assign trace_pc   = pc_w;
  assign trace_addr = write_reg_w;
  assign trace_data = wb_data_w;

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: vector table plus reset sweep and random traffic,
// expectations queued when driven and compared when sampled.
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write_w;
  logic [1:0]  wb_sel_w;
  logic [2:0]  load_type_w;
  logic [31:0] read_data_w, alu_out_w, pc_w, pc_plus_8_w, reg_data_w;
  logic [4:0]  write_reg_w, rs_addr_d, rt_addr_d;
  logic [31:0] rs_data_d, rt_data_d, wb_data_w, trace_pc, trace_data;
  logic        trace_en;
  logic [4:0]  trace_addr;

  always #5 clk = ~clk;

  wb_grf #(.NREG(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .reg_write_w(reg_write_w), .wb_sel_w(wb_sel_w),
    .load_type_w(load_type_w), .read_data_w(read_data_w), .alu_out_w(alu_out_w),
    .write_reg_w(write_reg_w), .pc_w(pc_w), .pc_plus_8_w(pc_plus_8_w),
    .reg_data_w(reg_data_w), .rs_addr_d(rs_addr_d), .rt_addr_d(rt_addr_d),
    .rs_data_d(rs_data_d), .rt_data_d(rt_data_d), .wb_data_w(wb_data_w),
    .trace_en(trace_en), .trace_pc(trace_pc), .trace_addr(trace_addr),
    .trace_data(trace_data)
  );

  typedef struct {
    logic        rst;
    logic        rw;
    logic [1:0]  sel;
    logic [2:0]  lt;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [31:0] aux;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] exp_wb;
  } vec_t;

  typedef struct {
    logic [31:0] wb;
    logic        ten;
    logic [31:0] tpc;
    logic [4:0]  taddr;
    logic [31:0] rs;
    logic [31:0] rt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  int          checks = 0;
  int          failures = 0;

  function automatic vec_t mk(input logic rst, input logic rw, input logic [1:0] sel,
                              input logic [2:0] lt, input logic [31:0] rd,
                              input logic [31:0] alu, input logic [4:0] wr,
                              input logic [31:0] pc, input logic [31:0] pc8,
                              input logic [31:0] aux, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [31:0] exp_wb);
    vec_t v;
    v.rst = rst; v.rw = rw; v.sel = sel; v.lt = lt; v.rd = rd; v.alu = alu;
    v.wr = wr; v.pc = pc; v.pc8 = pc8; v.aux = aux; v.rs = rs; v.rt = rt;
    v.exp_wb = exp_wb;
    return v;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic commit,
                                           input logic [4:0] wr, input logic [31:0] wb);
    if (a == 5'd0) return 32'h0;
    if (commit && a == wr) return wb;
    return model[a];
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    cmp({tag, ".wb_data"}, wb_data_w, e.wb);
    cmp({tag, ".trace_en"}, {31'b0, trace_en}, {31'b0, e.ten});
    cmp({tag, ".rs_data"}, rs_data_d, e.rs);
    cmp({tag, ".rt_data"}, rt_data_d, e.rt);
    if (e.ten) begin
      cmp({tag, ".trace_pc"}, trace_pc, e.tpc);
      cmp({tag, ".trace_addr"}, {27'b0, trace_addr}, {27'b0, e.taddr});
      cmp({tag, ".trace_data"}, trace_data, e.wb);
    end
  endtask

  // Drive one W-stage cycle, queue its expectations, sample mid-cycle, then advance the model.
  task automatic apply(input vec_t v, input string tag);
    exp_t  e;
    logic  commit;
    @(posedge clk); #1;
    reset = v.rst; reg_write_w = v.rw; wb_sel_w = v.sel; load_type_w = v.lt;
    read_data_w = v.rd; alu_out_w = v.alu; write_reg_w = v.wr; pc_w = v.pc;
    pc_plus_8_w = v.pc8; reg_data_w = v.aux; rs_addr_d = v.rs; rt_addr_d = v.rt;
    commit  = v.rw && !v.rst && (v.wr != 5'd0);
    e.wb    = v.exp_wb;
    e.ten   = commit;
    e.tpc   = v.pc;
    e.taddr = v.wr;
    e.rs    = ref_read(v.rs, commit, v.wr, v.exp_wb);
    e.rt    = ref_read(v.rt, commit, v.wr, v.exp_wb);
    sb.push_back(e);
    if (v.rst) for (int i = 0; i < 32; i++) model[i] = 32'h0;
    else if (commit) model[v.wr] = v.exp_wb;
    #3;
    check_out(tag);
  endtask

  localparam int NV = 22;
  localparam logic [31:0] RD = 32'h80FF_7F01;
  vec_t vecs [NV];

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    reset = 1'b1; reg_write_w = 1'b0; wb_sel_w = 2'd0; load_type_w = 3'd0;
    read_data_w = '0; alu_out_w = '0; write_reg_w = '0; pc_w = '0;
    pc_plus_8_w = '0; reg_data_w = '0; rs_addr_d = '0; rt_addr_d = '0;

    //             rst rw  sel  lt    rd     alu            wr     pc             pc8            aux            rs     rt     exp_wb
    vecs[0]  = mk(1, 0, 2'd0, 3'd0, 32'h0, 32'h0,         5'd0,  32'h0,         32'h0,         32'h0,         5'd0,  5'd0,  32'h0);
    vecs[1]  = mk(0, 1, 2'd0, 3'd0, 32'h0, 32'h1234_5678, 5'd8,  32'h0000_1000, 32'h0,         32'h0,         5'd8,  5'd0,  32'h1234_5678);
    vecs[2]  = mk(0, 0, 2'd0, 3'd0, 32'h0, 32'h0,         5'd8,  32'h0000_1004, 32'h0,         32'h0,         5'd8,  5'd9,  32'h0);
    vecs[3]  = mk(0, 1, 2'd0, 3'd0, 32'h0, 32'hFFFF_FFFF, 5'd0,  32'h0000_1008, 32'h0,         32'h0,         5'd0,  5'd8,  32'hFFFF_FFFF);
    vecs[4]  = mk(0, 0, 2'd0, 3'd0, 32'h0, 32'h0,         5'd0,  32'h0000_100C, 32'h0,         32'h0,         5'd0,  5'd0,  32'h0);
    vecs[5]  = mk(0, 1, 2'd1, 3'd2, RD,    32'h0000_0103, 5'd9,  32'h0000_2000, 32'h0,         32'h0,         5'd9,  5'd8,  32'hFFFF_FF80);
    vecs[6]  = mk(0, 1, 2'd1, 3'd1, RD,    32'h0000_0103, 5'd10, 32'h0000_2004, 32'h0,         32'h0,         5'd9,  5'd10, 32'h0000_0080);
    vecs[7]  = mk(0, 1, 2'd1, 3'd2, RD,    32'h0000_0100, 5'd11, 32'h0000_2008, 32'h0,         32'h0,         5'd11, 5'd10, 32'h0000_0001);
    vecs[8]  = mk(0, 1, 2'd1, 3'd4, RD,    32'h0000_0102, 5'd12, 32'h0000_200C, 32'h0,         32'h0,         5'd12, 5'd11, 32'hFFFF_80FF);
    vecs[9]  = mk(0, 1, 2'd1, 3'd3, RD,    32'h0000_0100, 5'd13, 32'h0000_2010, 32'h0,         32'h0,         5'd13, 5'd12, 32'h0000_7F01);
    vecs[10] = mk(0, 1, 2'd1, 3'd0, RD,    32'h0000_0102, 5'd14, 32'h0000_2014, 32'h0,         32'h0,         5'd14, 5'd13, 32'h80FF_7F01);
    vecs[11] = mk(0, 1, 2'd1, 3'd1, RD,    32'h0000_0101, 5'd15, 32'h0000_2018, 32'h0,         32'h0,         5'd15, 5'd14, 32'h0000_007F);
    vecs[12] = mk(0, 1, 2'd1, 3'd3, RD,    32'h0000_0103, 5'd16, 32'h0000_201C, 32'h0,         32'h0,         5'd15, 5'd16, 32'h0000_80FF);
    vecs[13] = mk(0, 1, 2'd1, 3'd6, RD,    32'h0000_0101, 5'd17, 32'h0000_2020, 32'h0,         32'h0,         5'd17, 5'd16, 32'h80FF_7F01);
    vecs[14] = mk(0, 1, 2'd1, 3'd4, RD,    32'h0000_0101, 5'd18, 32'h0000_2024, 32'h0,         32'h0,         5'd18, 5'd9,  32'h0000_7F01);
    vecs[15] = mk(0, 1, 2'd2, 3'd0, RD,    32'h0,         5'd31, 32'h0000_3000, 32'h0000_3008, 32'h0,         5'd31, 5'd18, 32'h0000_3008);
    vecs[16] = mk(0, 1, 2'd3, 3'd0, RD,    32'h0,         5'd20, 32'h0000_3004, 32'h0,         32'hDEAD_BEEF, 5'd31, 5'd20, 32'hDEAD_BEEF);
    vecs[17] = mk(0, 1, 2'd0, 3'd0, RD,    32'hCAFE_F00D, 5'd7,  32'h0000_3008, 32'h0,         32'h0,         5'd7,  5'd7,  32'hCAFE_F00D);
    vecs[18] = mk(0, 1, 2'd0, 3'd0, RD,    32'hAAAA_AAAA, 5'd5,  32'h0000_300C, 32'h0,         32'h0,         5'd20, 5'd7,  32'hAAAA_AAAA);
    vecs[19] = mk(1, 1, 2'd0, 3'd0, RD,    32'h5555_5555, 5'd5,  32'h0000_3010, 32'h0,         32'h0,         5'd5,  5'd20, 32'h5555_5555);
    vecs[20] = mk(0, 0, 2'd0, 3'd0, RD,    32'h0,         5'd5,  32'h0000_3014, 32'h0,         32'h0,         5'd5,  5'd20, 32'h0);
    vecs[21] = mk(0, 0, 2'd2, 3'd0, RD,    32'h0,         5'd0,  32'h0000_3018, 32'h0000_4444, 32'h0,         5'd31, 5'd7,  32'h0000_4444);

    apply(vecs[0], "reset");
    for (int i = 0; i < 32; i++)
      apply(mk(0, 0, 2'd0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0,
               5'(i), 5'(31 - i), 32'h0), "sweep");

    for (int i = 1; i < NV; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Random ALU-result traffic exercises every write address against both read ports.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] d;
      d = $urandom;
      apply(mk(0, 1'($urandom_range(0, 1)), 2'd0, 3'd0, 32'h0, d, 5'($urandom_range(0, 31)),
               32'h0000_5000 + 32'(i * 4), 32'h0, 32'h0,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), d), "rand");
    end

    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
